// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response, redirect and decode
// handshake signals of the fetch stage.  The optional trap flag exists only
// when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    , output fetch_misaligned
`endif
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    , input fetch_misaligned
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction fetch stage.  Holds the fetch PC, issues
// word reads under a credit limit of DEPTH (outstanding + buffered), tags
// each request with its PC, and buffers responses in an in-order FIFO whose
// head is presented to decode from registers.  A redirect flushes the FIFO
// and marks every in-flight response to be discarded.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect raises
// fetch_misaligned and halts fetch until an aligned redirect or reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = CW'(32'd1);
  localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO     = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE      = AW'(32'd1);

  logic [31:0]   fetch_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_r;
  logic [CW-1:0] fifo_count_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] tag_rd_r;
  logic [AW-1:0] tag_wr_r;
  logic [31:0]   fifo_data_r [DEPTH];
  logic [31:0]   fifo_pc_r   [DEPTH];
  logic [31:0]   tag_pc_r    [DEPTH];
  logic [31:0]   inst_data_r;
  logic [31:0]   inst_pc_r;

  logic          redirect_s;
  logic          redirect_bad_s;
  logic          halted_s;
  logic          credit_s;
  logic          req_valid_s;
  logic          accept_s;
  logic          rsp_s;
  logic          dropping_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   redirect_target_s;
  logic [31:0]   tag_head_s;
  logic [AW-1:0] rd_next_s;

  logic [31:0]   fetch_pc_n_s;
  logic [CW-1:0] outstanding_dec_s;
  logic [CW-1:0] outstanding_n_s;
  logic [CW-1:0] drop_n_s;
  logic [CW-1:0] fifo_count_n_s;
  logic [AW-1:0] rd_ptr_n_s;
  logic [AW-1:0] wr_ptr_n_s;
  logic [31:0]   head_data_n_s;
  logic [31:0]   head_pc_n_s;

  assign redirect_s        = bus.redirect_valid;
  assign redirect_target_s = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_r;
  assign redirect_bad_s       = redirect_s && (bus.redirect_pc[1:0] != 2'b00);
  assign halted_s             = misaligned_r;
  assign bus.fetch_misaligned = misaligned_r;

  // Trap flag: set by a misaligned redirect, cleared by an aligned one
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_r <= 1'b0;
    end else if (redirect_s) begin
      misaligned_r <= redirect_bad_s;
    end
  end
`else
  assign redirect_bad_s = 1'b0;
  assign halted_s       = 1'b0;
`endif

  // Requests are limited so every response always finds a FIFO slot
  assign credit_s    = ({1'b0, outstanding_r} + {1'b0, fifo_count_r}) < CREDIT_LIMIT;
  assign req_valid_s = !reset && !redirect_s && !halted_s && credit_s;
  assign accept_s    = req_valid_s && bus.imem_req_ready;
  assign rsp_s       = bus.imem_rsp_valid;
  assign dropping_s  = (drop_r != CNT_ZERO);
  assign push_s      = rsp_s && !dropping_s && !redirect_s;
  assign pop_s       = (fifo_count_r != CNT_ZERO) && bus.inst_ready && !redirect_s;
  assign tag_head_s  = tag_pc_r[tag_rd_r];
  assign rd_next_s   = rd_ptr_r + PTR_ONE;

  // Next-state for PC, credit/drop counters, FIFO pointers and head registers
  always_comb begin
    fetch_pc_n_s      = fetch_pc_r;
    outstanding_dec_s = outstanding_r;
    outstanding_n_s   = outstanding_r;
    drop_n_s          = drop_r;
    fifo_count_n_s    = fifo_count_r;
    rd_ptr_n_s        = rd_ptr_r;
    wr_ptr_n_s        = wr_ptr_r;
    head_data_n_s     = inst_data_r;
    head_pc_n_s       = inst_pc_r;

    if (rsp_s) begin
      outstanding_dec_s = outstanding_r - CNT_ONE;
    end else begin
      outstanding_dec_s = outstanding_r;
    end

    if (accept_s) begin
      outstanding_n_s = outstanding_dec_s + CNT_ONE;
    end else begin
      outstanding_n_s = outstanding_dec_s;
    end

    if (redirect_s) begin
      // Everything still in flight after this cycle's response is stale
      drop_n_s       = outstanding_dec_s;
      fifo_count_n_s = CNT_ZERO;
      rd_ptr_n_s     = PTR_ZERO;
      wr_ptr_n_s     = PTR_ZERO;
      if (redirect_bad_s) begin
        fetch_pc_n_s = fetch_pc_r;
      end else begin
        fetch_pc_n_s = redirect_target_s;
      end
    end else begin
      if (rsp_s && dropping_s) begin
        drop_n_s = drop_r - CNT_ONE;
      end else begin
        drop_n_s = drop_r;
      end
      if (accept_s) begin
        fetch_pc_n_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_n_s = fetch_pc_r;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_n_s = fifo_count_r + CNT_ONE;
        2'b01:   fifo_count_n_s = fifo_count_r - CNT_ONE;
        default: fifo_count_n_s = fifo_count_r;
      endcase
      if (push_s) begin
        wr_ptr_n_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_n_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_n_s = rd_next_s;
      end else begin
        rd_ptr_n_s = rd_ptr_r;
      end
    end

    // Head registers show next cycle's FIFO head, or hold when it goes empty
    if (fifo_count_n_s == CNT_ZERO) begin
      head_data_n_s = inst_data_r;
      head_pc_n_s   = inst_pc_r;
    end else if (pop_s) begin
      if (fifo_count_r > CNT_ONE) begin
        head_data_n_s = fifo_data_r[rd_next_s];
        head_pc_n_s   = fifo_pc_r[rd_next_s];
      end else begin
        head_data_n_s = bus.imem_rsp_data;
        head_pc_n_s   = tag_head_s;
      end
    end else if (fifo_count_r == CNT_ZERO) begin
      head_data_n_s = bus.imem_rsp_data;
      head_pc_n_s   = tag_head_s;
    end else begin
      head_data_n_s = fifo_data_r[rd_ptr_r];
      head_pc_n_s   = fifo_pc_r[rd_ptr_r];
    end
  end

  // Control state and registered decode outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      drop_r        <= CNT_ZERO;
      fifo_count_r  <= CNT_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      tag_rd_r      <= PTR_ZERO;
      tag_wr_r      <= PTR_ZERO;
      inst_data_r   <= 32'h0000_0000;
      inst_pc_r     <= 32'h0000_0000;
    end else begin
      fetch_pc_r    <= fetch_pc_n_s;
      outstanding_r <= outstanding_n_s;
      drop_r        <= drop_n_s;
      fifo_count_r  <= fifo_count_n_s;
      rd_ptr_r      <= rd_ptr_n_s;
      wr_ptr_r      <= wr_ptr_n_s;
      inst_data_r   <= head_data_n_s;
      inst_pc_r     <= head_pc_n_s;
      if (accept_s) begin
        tag_wr_r <= tag_wr_r + PTR_ONE;
      end
      if (rsp_s) begin
        tag_rd_r <= tag_rd_r + PTR_ONE;
      end
    end
  end

  // Storage for buffered instructions and request PC tags (no reset needed)
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= bus.imem_rsp_data;
      fifo_pc_r[wr_ptr_r]   <= tag_head_s;
    end
    if (accept_s) begin
      tag_pc_r[tag_wr_r] <= fetch_pc_r;
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign bus.inst_valid     = (fifo_count_r != CNT_ZERO);
  assign bus.inst_data      = inst_data_r;
  assign bus.inst_pc        = inst_pc_r;

  fetch_unit_chk #(.DEPTH(DEPTH), .CW(CW)) chk (
    .clk         (clk),
    .reset       (reset),
    .outstanding (outstanding_r),
    .fifo_count  (fifo_count_r),
    .drop        (drop_r)
  );
endmodule

// fetch_unit_chk: occupancy invariants of the fetch stage counters.
module fetch_unit_chk #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input logic          clk,
  input logic          reset,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] fifo_count,
  input logic [CW-1:0] drop
);
  localparam logic [CW-1:0] LIMIT = CW'(DEPTH);

  a_outstanding: assert property (@(posedge clk) disable iff (reset) outstanding <= LIMIT);
  a_fifo_count:  assert property (@(posedge clk) disable iff (reset) fifo_count <= LIMIT);
  a_drop:        assert property (@(posedge clk) disable iff (reset) drop <= outstanding);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit (DEPTH = 2, RESET_PC = 0).
// Expected request addresses and expected (pc, data) deliveries are queued
// as each scenario is set up and popped as the DUT produces them.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic [31:0] mem_q[$];
  logic rsp_hold = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
  endfunction

  // Memory model: record accepted requests
  always @(posedge clk) begin
    if (reset) mem_q.delete();
    else if (bus.imem_req_valid && bus.imem_req_ready) mem_q.push_back(bus.imem_req_addr);
  end

  // Memory model: answer in order, one cycle after acceptance unless held
  always @(negedge clk) begin
    logic [31:0] a;
    if (!rsp_hold && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(a);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0000_0000;
    end
  end

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    rsp_hold = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0000_0000;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = rdy;
    exp_req.delete();
    exp_pc.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] e;
    do_reset(1'b1);
    exp_req = '{32'h0, 32'h4, 32'h8};
    exp_pc  = '{32'h0, 32'h4, 32'h8};
    for (int c = 0; c < 14; c++) begin
      #1;
      if (bus.imem_req_valid && bus.imem_req_ready && exp_req.size() > 0) begin
        e = exp_req.pop_front(); n_checks++;
        if (bus.imem_req_addr !== e) begin
          n_fail++; $display("FAIL basic_req: got %h expected %h", bus.imem_req_addr, e);
        end
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid && exp_pc.size() > 0) begin
        e = exp_pc.pop_front(); n_checks++;
        if (bus.inst_pc !== e || bus.inst_data !== mem_word(e)) begin
          n_fail++; $display("FAIL basic_inst: got pc %h data %h expected pc %h data %h", bus.inst_pc, bus.inst_data, e, mem_word(e));
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_req.size() != 0 || exp_pc.size() != 0) begin
      n_fail++; $display("FAIL basic_drain: got %0d/%0d left expected 0/0", exp_req.size(), exp_pc.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.inst_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_comb: got %b expected 0", bus.imem_req_valid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valids: got req %b inst %b expected 0 0", bus.imem_req_valid, bus.inst_valid);
    end
    n_checks++;
    if (bus.inst_data !== 32'h0 || bus.inst_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_inst: got data %h pc %h expected 0 0", bus.inst_data, bus.inst_pc);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    n_checks++;
    if (bus.fetch_misaligned !== 1'b0) begin
      n_fail++; $display("FAIL reset_misaligned: got %b expected 0", bus.fetch_misaligned);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    bus.inst_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_first_req: got valid %b addr %h expected 1 00000000", bus.imem_req_valid, bus.imem_req_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    int nreq;
    nreq = 0;
    do_reset(1'b0);
    exp_req = '{32'h0, 32'h4, 32'h8};
    exp_pc  = '{32'h0, 32'h4, 32'h8};
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        nreq++;
        if (exp_req.size() > 0) begin
          e = exp_req.pop_front(); n_checks++;
          if (bus.imem_req_addr !== e) begin
            n_fail++; $display("FAIL bp_req: got %h expected %h", bus.imem_req_addr, e);
          end
        end
      end
      if (c >= 4) begin
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_data !== mem_word(32'h0)) begin
          n_fail++; $display("FAIL bp_hold: got valid %b pc %h data %h expected 1 00000000 %h", bus.inst_valid, bus.inst_pc, bus.inst_data, mem_word(32'h0));
        end
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (nreq != 2 || bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_credit: got %0d reqs valid %b expected 2 reqs valid 0", nreq, bus.imem_req_valid);
    end
    @(negedge clk);
    bus.inst_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.imem_req_valid && bus.imem_req_ready && exp_req.size() > 0) begin
        e = exp_req.pop_front(); n_checks++;
        if (bus.imem_req_addr !== e) begin
          n_fail++; $display("FAIL bp_resume_req: got %h expected %h", bus.imem_req_addr, e);
        end
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid && exp_pc.size() > 0) begin
        e = exp_pc.pop_front(); n_checks++;
        if (bus.inst_pc !== e || bus.inst_data !== mem_word(e)) begin
          n_fail++; $display("FAIL bp_inst: got pc %h data %h expected pc %h data %h", bus.inst_pc, bus.inst_data, e, mem_word(e));
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_req.size() != 0 || exp_pc.size() != 0) begin
      n_fail++; $display("FAIL bp_drain: got %0d/%0d left expected 0/0", exp_req.size(), exp_pc.size());
    end
  endtask

  // Redirect with two fetches held in flight; both responses must vanish
  task automatic test_redirect_inflight();
    logic [31:0] e;
    do_reset(1'b1);
    rsp_hold = 1'b1;
    exp_req = '{32'h0, 32'h4, 32'h100, 32'h104};
    exp_pc  = '{32'h100, 32'h104};
    for (int c = 0; c < 16; c++) begin
      if (c == 2) begin
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0100;
      end
      if (c == 3) begin
        bus.redirect_valid = 1'b0; rsp_hold = 1'b0;
      end
      #1;
      if (c == 2) begin
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
          n_fail++; $display("FAIL rdi_req_in_redirect: got %b expected 0", bus.imem_req_valid);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (bus.inst_valid !== 1'b0) begin
          n_fail++; $display("FAIL rdi_flush: got inst_valid %b expected 0", bus.inst_valid);
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready && exp_req.size() > 0) begin
        e = exp_req.pop_front(); n_checks++;
        if (bus.imem_req_addr !== e) begin
          n_fail++; $display("FAIL rdi_req: got %h expected %h", bus.imem_req_addr, e);
        end
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid && exp_pc.size() > 0) begin
        e = exp_pc.pop_front(); n_checks++;
        if (bus.inst_pc !== e || bus.inst_data !== mem_word(e)) begin
          n_fail++; $display("FAIL rdi_inst: got pc %h data %h expected pc %h data %h", bus.inst_pc, bus.inst_data, e, mem_word(e));
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_req.size() != 0 || exp_pc.size() != 0) begin
      n_fail++; $display("FAIL rdi_drain: got %0d/%0d left expected 0/0", exp_req.size(), exp_pc.size());
    end
  endtask

  // Redirect in the same cycle as a response and a decode pop
  task automatic test_redirect_pop();
    logic [31:0] e;
    do_reset(1'b1);
    exp_req = '{32'h0, 32'h4, 32'h200, 32'h204};
    exp_pc  = '{32'h200, 32'h204};
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
      end
      if (c == 3) bus.redirect_valid = 1'b0;
      #1;
      if (c == 2) begin
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.imem_rsp_valid !== 1'b1) begin
          n_fail++; $display("FAIL rdp_setup: got inst_valid %b pc %h rsp %b expected 1 00000000 1", bus.inst_valid, bus.inst_pc, bus.imem_rsp_valid);
        end
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
          n_fail++; $display("FAIL rdp_req_in_redirect: got %b expected 0", bus.imem_req_valid);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (bus.inst_valid !== 1'b0) begin
          n_fail++; $display("FAIL rdp_flush: got inst_valid %b expected 0", bus.inst_valid);
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready && exp_req.size() > 0) begin
        e = exp_req.pop_front(); n_checks++;
        if (bus.imem_req_addr !== e) begin
          n_fail++; $display("FAIL rdp_req: got %h expected %h", bus.imem_req_addr, e);
        end
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid && exp_pc.size() > 0) begin
        e = exp_pc.pop_front(); n_checks++;
        if (bus.inst_pc !== e || bus.inst_data !== mem_word(e)) begin
          n_fail++; $display("FAIL rdp_inst: got pc %h data %h expected pc %h data %h", bus.inst_pc, bus.inst_data, e, mem_word(e));
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_req.size() != 0 || exp_pc.size() != 0) begin
      n_fail++; $display("FAIL rdp_drain: got %0d/%0d left expected 0/0", exp_req.size(), exp_pc.size());
    end
  endtask

  // PC wraps from the top word to zero
  task automatic test_wrap();
    logic [31:0] e;
    do_reset(1'b1);
    exp_req = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    exp_pc  = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
      end
      if (c == 1) bus.redirect_valid = 1'b0;
      #1;
      if (c == 0) begin
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
          n_fail++; $display("FAIL wrap_req_in_redirect: got %b expected 0", bus.imem_req_valid);
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready && exp_req.size() > 0) begin
        e = exp_req.pop_front(); n_checks++;
        if (bus.imem_req_addr !== e) begin
          n_fail++; $display("FAIL wrap_req: got %h expected %h", bus.imem_req_addr, e);
        end
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid && exp_pc.size() > 0) begin
        e = exp_pc.pop_front(); n_checks++;
        if (bus.inst_pc !== e || bus.inst_data !== mem_word(e)) begin
          n_fail++; $display("FAIL wrap_inst: got pc %h data %h expected pc %h data %h", bus.inst_pc, bus.inst_data, e, mem_word(e));
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_req.size() != 0 || exp_pc.size() != 0) begin
      n_fail++; $display("FAIL wrap_drain: got %0d/%0d left expected 0/0", exp_req.size(), exp_pc.size());
    end
  endtask

  // Redirect to a misaligned target (trap or silent alignment)
  task automatic test_misalign();
    logic [31:0] e;
    do_reset(1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_req = '{32'h200, 32'h204};
    exp_pc  = '{32'h200, 32'h204};
`else
    exp_req = '{32'h100, 32'h104};
    exp_pc  = '{32'h100, 32'h104};
`endif
    for (int c = 0; c < 16; c++) begin
      if (c == 0) begin
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0102;
      end
      if (c == 1) bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (c == 6) begin
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
      end
      if (c == 7) bus.redirect_valid = 1'b0;
`endif
      #1;
      if (c == 0) begin
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
          n_fail++; $display("FAIL mis_req_in_redirect: got %b expected 0", bus.imem_req_valid);
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (c >= 1 && c <= 5) begin
        n_checks++;
        if (bus.fetch_misaligned !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
          n_fail++; $display("FAIL mis_trap: got flag %b req %b expected 1 0", bus.fetch_misaligned, bus.imem_req_valid);
        end
      end
      if (c == 7) begin
        n_checks++;
        if (bus.fetch_misaligned !== 1'b0) begin
          n_fail++; $display("FAIL mis_clear: got flag %b expected 0", bus.fetch_misaligned);
        end
      end
`endif
      if (bus.imem_req_valid && bus.imem_req_ready && exp_req.size() > 0) begin
        e = exp_req.pop_front(); n_checks++;
        if (bus.imem_req_addr !== e) begin
          n_fail++; $display("FAIL mis_req: got %h expected %h", bus.imem_req_addr, e);
        end
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid && exp_pc.size() > 0) begin
        e = exp_pc.pop_front(); n_checks++;
        if (bus.inst_pc !== e || bus.inst_data !== mem_word(e)) begin
          n_fail++; $display("FAIL mis_inst: got pc %h data %h expected pc %h data %h", bus.inst_pc, bus.inst_data, e, mem_word(e));
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_req.size() != 0 || exp_pc.size() != 0) begin
      n_fail++; $display("FAIL mis_drain: got %0d/%0d left expected 0/0", exp_req.size(), exp_pc.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0000_0000;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    test_basic();
    test_reset();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pop();
    test_wrap();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
